// File: rtl/phase_ramp_ctrl_pkg.sv
// Shared types and constants for the gyro phase-ramp closed-loop sequencer.
// Default widths, FSM state encoding, reset gain and integrator saturation limits.
package phase_ramp_ctrl_pkg;

  localparam int unsigned DATA_BIT_DEF   = 16;
  localparam int unsigned ERR_BIT_DEF    = 16;
  localparam int unsigned ACC_BIT_DEF    = 32;
  localparam int unsigned SETTLE_CYC_DEF = 1000;
  localparam int unsigned KI_BIT         = 4;
  localparam int unsigned GAIN_BIT       = 4;
  localparam int unsigned STATE_BIT      = 2;

  typedef enum logic [STATE_BIT-1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_RUN     = 2'd2,
    ST_GAIN_SW = 2'd3
  } state_t;

  localparam logic [GAIN_BIT-1:0] GAIN_SEL_RST = 4'd5;

  // Integrator rails for the default accumulator width.
  localparam logic signed [ACC_BIT_DEF-1:0] ACC_MAX = {1'b0, {(ACC_BIT_DEF-1){1'b1}}};
  localparam logic signed [ACC_BIT_DEF-1:0] ACC_MIN = {1'b1, {(ACC_BIT_DEF-1){1'b0}}};

endpackage

// File: rtl/phase_ramp_ctrl_if.sv
// Demodulator/host-side bus of the phase-ramp sequencer and its ramp-generator outputs.
// master = host/demodulator side, slave = the sequencer.
interface phase_ramp_ctrl_if #(
  parameter int unsigned ERR_BIT  = phase_ramp_ctrl_pkg::ERR_BIT_DEF,
  parameter int unsigned DATA_BIT = phase_ramp_ctrl_pkg::DATA_BIT_DEF
) ();

  logic                                          i_fb_req;
  logic signed [ERR_BIT-1:0]                     i_err;
  logic                                          i_err_vld;
  logic [phase_ramp_ctrl_pkg::KI_BIT-1:0]        i_ki_shift;
  logic [phase_ramp_ctrl_pkg::GAIN_BIT-1:0]      i_gain_sel;
  logic                                          i_gain_upd;
  logic                                          o_fb_on;
  logic                                          o_trig;
  logic signed [DATA_BIT-1:0]                    o_step;
  logic [phase_ramp_ctrl_pkg::GAIN_BIT-1:0]      o_gain_sel;
  logic [phase_ramp_ctrl_pkg::STATE_BIT-1:0]     o_state;

  modport master (
    output i_fb_req, i_err, i_err_vld, i_ki_shift, i_gain_sel, i_gain_upd,
    input  o_fb_on, o_trig, o_step, o_gain_sel, o_state
  );

  modport slave (
    input  i_fb_req, i_err, i_err_vld, i_ki_shift, i_gain_sel, i_gain_upd,
    output o_fb_on, o_trig, o_step, o_gain_sel, o_state
  );

endinterface

// File: rtl/phase_ramp_ctrl_ramp_step_integ.sv
// Saturating signed integrator: acc += err >>> shift, with synchronous clear.
// The ramp step is the upper DATA_BIT bits of the accumulator.
module ramp_step_integ #(
  parameter int unsigned DATA_BIT = 16,
  parameter int unsigned ERR_BIT  = 16,
  parameter int unsigned ACC_BIT  = 32,
  parameter int unsigned KI_BIT   = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       en_i,
  input  logic signed [ERR_BIT-1:0]  err_i,
  input  logic [KI_BIT-1:0]          shift_i,
  output logic signed [DATA_BIT-1:0] step_o
);

  localparam logic signed [ACC_BIT-1:0] SAT_MAX = {1'b0, {(ACC_BIT-1){1'b1}}};
  localparam logic signed [ACC_BIT-1:0] SAT_MIN = {1'b1, {(ACC_BIT-1){1'b0}}};

  logic signed [ACC_BIT-1:0] acc_q, acc_d;
  logic signed [ACC_BIT-1:0] err_ext;
  logic signed [ACC_BIT-1:0] inc;
  logic signed [ACC_BIT:0]   sum;

  // One guard bit catches overflow; differing top two bits select the rail.
  always_comb begin
    err_ext = ACC_BIT'(err_i);
    inc     = err_ext >>> shift_i;
    sum     = (ACC_BIT+1)'(acc_q) + (ACC_BIT+1)'(inc);
    acc_d   = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      if (sum[ACC_BIT] != sum[ACC_BIT-1]) begin
        acc_d = sum[ACC_BIT] ? SAT_MIN : SAT_MAX;
      end else begin
        acc_d = sum[ACC_BIT-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign step_o = acc_q[ACC_BIT-1 -: DATA_BIT];

endmodule

// File: rtl/phase_ramp_ctrl.sv
// Closed-loop bring-up sequencer for the gyro phase-ramp generator:
// open loop -> settle -> closed loop, with gain changes applied only at safe points.
module phase_ramp_ctrl
  import phase_ramp_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BIT   = DATA_BIT_DEF,
  parameter int unsigned ERR_BIT    = ERR_BIT_DEF,
  parameter int unsigned ACC_BIT    = ACC_BIT_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  phase_ramp_ctrl_if.slave   bus
);

  localparam int unsigned SETTLE_EFF = (SETTLE_CYC == 0) ? 1 : SETTLE_CYC;
  localparam int unsigned CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GAIN_BIT-1:0] gain_q, gain_d;
  logic                trig_q, trig_d;
  logic                fb_on_q, fb_on_d;
  logic                integ_clr;
  logic                integ_en;

  // Next-state, settle counter, gain latch and integrator control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gain_d    = gain_q;
    trig_d    = 1'b0;
    fb_on_d   = 1'b0;
    integ_clr = 1'b0;
    integ_en  = 1'b0;

    if (bus.i_gain_upd) begin
      gain_d = bus.i_gain_sel;
    end

    if (!bus.i_fb_req) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
        ST_SETTLE: begin
          if (bus.i_gain_upd) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (bus.i_gain_upd) begin
            state_d = ST_GAIN_SW;
          end
        end
        ST_GAIN_SW: begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Accumulator is only live while staying in RUN; any exit clears it.
    integ_clr = (state_d != ST_RUN);
    integ_en  = (state_q == ST_RUN) && (state_d == ST_RUN) && bus.i_err_vld;
    trig_d    = integ_en;
    fb_on_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gain_q  <= GAIN_SEL_RST;
      trig_q  <= 1'b0;
      fb_on_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gain_q  <= gain_d;
      trig_q  <= trig_d;
      fb_on_q <= fb_on_d;
    end
  end

  ramp_step_integ #(
    .DATA_BIT (DATA_BIT),
    .ERR_BIT  (ERR_BIT),
    .ACC_BIT  (ACC_BIT),
    .KI_BIT   (KI_BIT)
  ) u_integ (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .clr_i   (integ_clr),
    .en_i    (integ_en),
    .err_i   (bus.i_err),
    .shift_i (bus.i_ki_shift),
    .step_o  (bus.o_step)
  );

  assign bus.o_fb_on    = fb_on_q;
  assign bus.o_trig     = trig_q;
  assign bus.o_gain_sel = gain_q;
  assign bus.o_state    = state_q;

endmodule

// File: doc/phase_ramp_ctrl.md
# phase_ramp_ctrl

Closed-loop sequencer for the gyro phase-ramp generator. Sequences feedback bring-up: open loop, settle, then closed loop. Integrates demodulated rate-error samples into the ramp step, issues one ramp trigger per error sample, and applies gain-select changes only at safe points so the ramp never jumps mid-staircase. Sits between the demodulator output and the phase ramp generator's step/trig/fb_on/gain_sel inputs.

## Interface
- DATA_BIT, 16: width of o_step (matches ramp generator OUTPUT_BIT).
- ERR_BIT, 16: width of signed error input.
- ACC_BIT, 32: integrator width; must be ≥ DATA_BIT and ≥ ERR_BIT.
- SETTLE_CYC, 1000: cycles spent in SETTLE before closing the loop (0 treated as 1).
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_fb_req  in  1  host level: 1 = request closed loop, 0 = open loop.
- i_err  in  ERR_BIT signed  demodulated error sample.
- i_err_vld  in  1  one-cycle strobe qualifying i_err.
- i_ki_shift  in  4  integrator gain; sample added as i_err >>> i_ki_shift (sign-extended to ACC_BIT).
- i_gain_sel  in  4  requested ramp gain select.
- i_gain_upd  in  1  one-cycle strobe to apply i_gain_sel.
- o_fb_on  out  1  to ramp generator fb enable.
- o_trig  out  1  one-cycle ramp advance strobe.
- o_step  out  DATA_BIT signed  ramp step.
- o_gain_sel  out  4  applied gain select.
- o_state  out  2  current FSM state (IDLE=0, SETTLE=1, RUN=2, GAIN_SW=3).

## Operation
- Reset values: state IDLE, acc 0, o_step 0, o_trig 0, o_fb_on 0, o_gain_sel 4'd5, settle count 0.
- IDLE: o_fb_on 0, acc held at 0. i_fb_req=1 → SETTLE.
- SETTLE: o_fb_on 0, acc 0, counter counts 0..SETTLE_CYC-1, then → RUN. Error strobes ignored, no trig.
- RUN: o_fb_on 1. Each i_err_vld: acc ← sat(acc + (i_err >>> i_ki_shift)), saturating at ±(2^(ACC_BIT-1)-1) / -2^(ACC_BIT-1). o_step = acc[ACC_BIT-1 -: DATA_BIT] (upper bits, arithmetic truncation).
- GAIN_SW: exactly one cycle; o_fb_on 0 (ramp ladder clears), acc cleared, o_gain_sel ← latched request; → SETTLE with count restarted.
- Gain update in IDLE: o_gain_sel updated next cycle, stay IDLE. In SETTLE: o_gain_sel updated, settle count restarts at 0. In RUN: latch value, → GAIN_SW.
- Priority: i_fb_req=0 overrides all; any state → IDLE next cycle, acc cleared, pending gain still applied. Gain update beats an error strobe in the same RUN cycle (that sample is dropped, no trig).
- o_step is 0 whenever not in RUN.

## Timing
- i_err_vld at cycle n (state RUN) → acc/o_step updated at n+1, o_trig=1 during n+1 only; o_step stable while o_trig high.
- Back-to-back strobes: one trig per strobe, each trig one cycle after its strobe.
- i_fb_req rise at n → SETTLE at n+1 → RUN at n+1+SETTLE_CYC; o_fb_on rises with RUN.
- i_gain_upd in RUN at n → GAIN_SW at n+1 (o_fb_on 0, new o_gain_sel visible) → SETTLE n+2 → RUN n+2+SETTLE_CYC.
- Async reset mid-RUN: all outputs to reset values immediately; on release, IDLE, and i_fb_req still high → SETTLE next cycle.

## Structure
- Shared package: state enum (IDLE/SETTLE/RUN/GAIN_SW), GAIN_SEL_RST = 4'd5, saturation limit constants derived from ACC_BIT.
- Sub-module ramp_step_integ: saturating signed accumulator with shift, clear and enable; FSM, settle counter and gain latch in the top.

## Test plan
- Reset then i_fb_req=1, SETTLE_CYC=4 → o_state 1 for 4 cycles, o_fb_on rises on cycle 5, o_gain_sel=5, o_step=0.
- RUN, ACC_BIT=32, DATA_BIT=16, ki_shift=0, three strobes of i_err=16'h0100 → acc=0x300, o_step=0 (upper bits); with i_err=16'h7FFF repeated 70000 times → acc saturates at 0x7FFFFFFF, o_step=16'h7FFF, no wrap; one trig per strobe, one cycle later.
- Negative error i_err=-16'd8, ki_shift=2 → acc decrements by 2 per strobe, o_step=16'hFFFF after first strobe.
- i_gain_sel=3 with i_gain_upd and i_err_vld same RUN cycle → no trig, GAIN_SW one cycle with o_fb_on 0, o_gain_sel=3, acc=0, then SETTLE.
- i_fb_req dropped mid-RUN → IDLE next cycle, o_fb_on 0, o_step 0; re-raise restarts full settle.
- Assert i_rst mid-SETTLE asynchronously → outputs reset without a clock edge; gain_sel returns to 5.
